// File: rtl/morse_uart_decoder.sv
// Morse decoder with UART output. Button mode takes discrete dot/dash/space
// pulses; timed mode classifies a keyed carrier line against DOT_TICKS.
// Decoded ASCII is buffered in a small FIFO and sent as 8N1 serial.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   mode                  0 = button mode, 1 = timed mode
//   dot_inp .. word_space_inp  button inputs (async, rising edge)
//   rx_cw                 timed-mode key line (async, high = key down)
//   tx                    UART 8N1 output, idle high
//   char_out/char_valid   last pushed ASCII value / one-cycle push pulse
//   fifo_full, overflow   FIFO full / sticky dropped-push flag
//   busy                  UART frame in progress
module morse_uart_decoder #(
  parameter int unsigned BAUD_DIV   = 87,
  parameter int unsigned MAX_SYMS   = 6,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DOT_TICKS  = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode,
  input  logic       dot_inp,
  input  logic       dash_inp,
  input  logic       char_space_inp,
  input  logic       word_space_inp,
  input  logic       rx_cw,
  output logic       tx,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic       fifo_full,
  output logic       overflow,
  output logic       busy
);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned CW   = $clog2(7 * DOT_TICKS + 1);
  localparam int unsigned BW   = $clog2(BAUD_DIV);
  localparam int unsigned LW   = 3;

  typedef enum logic {U_IDLE, U_SEND} uart_state_e;

  // Input synchronisers; third stage gives the previous synchronised value.
  logic [5:0] sync1_q, sync2_q, sync3_q;
  logic [3:0] btn_edge_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      sync3_q    <= '0;
      btn_edge_q <= '0;
    end else begin
      sync1_q    <= {mode, rx_cw, word_space_inp, char_space_inp, dash_inp, dot_inp};
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      btn_edge_q <= sync2_q[3:0] & ~sync3_q[3:0];
    end
  end

  logic mode_s, mode_chg, rx_s, rx_tog, rx_fall;
  assign mode_s   = sync2_q[5];
  assign mode_chg = sync2_q[5] ^ sync3_q[5];
  assign rx_s     = sync2_q[4];
  assign rx_tog   = sync2_q[4] ^ sync3_q[4];
  assign rx_fall  = sync3_q[4] & ~sync2_q[4];

  logic [CW-1:0]       tcnt_q;
  logic                armed_q;
  logic [MAX_SYMS-1:0] sym_q;
  logic [LW-1:0]       len_q;
  logic                bad_q, space_pend_q, last_space_q;
  logic                elem_v_c, elem_dash_c, char_end_c, word_end_c;
  logic                push_c;
  logic [7:0]          push_data_c;

  function automatic logic [7:0] morse_lookup(input logic [LW-1:0] n, input logic [4:0] p);
    case ({n, p})
      {3'd1, 5'b00000}: morse_lookup = 8'h45; // E
      {3'd1, 5'b00001}: morse_lookup = 8'h54; // T
      {3'd2, 5'b00000}: morse_lookup = 8'h49; // I
      {3'd2, 5'b00001}: morse_lookup = 8'h41; // A
      {3'd2, 5'b00010}: morse_lookup = 8'h4E; // N
      {3'd2, 5'b00011}: morse_lookup = 8'h4D; // M
      {3'd3, 5'b00000}: morse_lookup = 8'h53; // S
      {3'd3, 5'b00001}: morse_lookup = 8'h55; // U
      {3'd3, 5'b00010}: morse_lookup = 8'h52; // R
      {3'd3, 5'b00011}: morse_lookup = 8'h57; // W
      {3'd3, 5'b00100}: morse_lookup = 8'h44; // D
      {3'd3, 5'b00101}: morse_lookup = 8'h4B; // K
      {3'd3, 5'b00110}: morse_lookup = 8'h47; // G
      {3'd3, 5'b00111}: morse_lookup = 8'h4F; // O
      {3'd4, 5'b00000}: morse_lookup = 8'h48; // H
      {3'd4, 5'b00001}: morse_lookup = 8'h56; // V
      {3'd4, 5'b00010}: morse_lookup = 8'h46; // F
      {3'd4, 5'b00100}: morse_lookup = 8'h4C; // L
      {3'd4, 5'b00110}: morse_lookup = 8'h50; // P
      {3'd4, 5'b00111}: morse_lookup = 8'h4A; // J
      {3'd4, 5'b01000}: morse_lookup = 8'h42; // B
      {3'd4, 5'b01001}: morse_lookup = 8'h58; // X
      {3'd4, 5'b01010}: morse_lookup = 8'h43; // C
      {3'd4, 5'b01011}: morse_lookup = 8'h59; // Y
      {3'd4, 5'b01100}: morse_lookup = 8'h5A; // Z
      {3'd4, 5'b01101}: morse_lookup = 8'h51; // Q
      {3'd5, 5'b11111}: morse_lookup = 8'h30;
      {3'd5, 5'b01111}: morse_lookup = 8'h31;
      {3'd5, 5'b00111}: morse_lookup = 8'h32;
      {3'd5, 5'b00011}: morse_lookup = 8'h33;
      {3'd5, 5'b00001}: morse_lookup = 8'h34;
      {3'd5, 5'b00000}: morse_lookup = 8'h35;
      {3'd5, 5'b10000}: morse_lookup = 8'h36;
      {3'd5, 5'b11000}: morse_lookup = 8'h37;
      {3'd5, 5'b11100}: morse_lookup = 8'h38;
      {3'd5, 5'b11110}: morse_lookup = 8'h39;
      default:          morse_lookup = 8'h3F;
    endcase
  endfunction

  // Timed-mode duration counter. armed_q keeps an idle line from emitting
  // char/word ends until at least one element has been keyed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q  <= '0;
      armed_q <= 1'b0;
    end else if (mode_chg || !mode_s) begin
      tcnt_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      if (rx_tog)                             tcnt_q <= CW'(1);
      else if (tcnt_q != CW'(7 * DOT_TICKS))  tcnt_q <= tcnt_q + CW'(1);
      if (rx_fall)         armed_q <= 1'b1;
      else if (word_end_c) armed_q <= 1'b0;
    end
  end

  // Event decode: one element/char end/word end per cycle.
  always_comb begin
    elem_v_c    = 1'b0;
    elem_dash_c = 1'b0;
    char_end_c  = 1'b0;
    word_end_c  = 1'b0;
    if (!mode_chg) begin
      if (mode_s) begin
        elem_v_c    = rx_fall;
        elem_dash_c = (tcnt_q >= CW'(2 * DOT_TICKS));
        char_end_c  = armed_q && !rx_tog && !rx_s && (tcnt_q == CW'(3 * DOT_TICKS - 1));
        word_end_c  = armed_q && !rx_tog && !rx_s && (tcnt_q == CW'(7 * DOT_TICKS - 1));
      end else if (btn_edge_q[3]) begin
        word_end_c = 1'b1;
      end else if (btn_edge_q[2]) begin
        char_end_c = 1'b1;
      end else if (btn_edge_q[1] || btn_edge_q[0]) begin
        elem_v_c    = 1'b1;
        elem_dash_c = btn_edge_q[1];
      end
    end
  end

  // Push selection; the deferred space of a word end takes its own cycle.
  always_comb begin
    push_c      = 1'b0;
    push_data_c = 8'h00;
    if (space_pend_q) begin
      push_c      = 1'b1;
      push_data_c = 8'h20;
    end else if ((char_end_c || word_end_c) && (len_q != '0)) begin
      push_c      = 1'b1;
      push_data_c = bad_q ? 8'h3F : morse_lookup(len_q, sym_q[4:0]);
    end else if (word_end_c && !last_space_q) begin
      push_c      = 1'b1;
      push_data_c = 8'h20;
    end
  end

  // Symbol register and word-space bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_q        <= '0;
      len_q        <= '0;
      bad_q        <= 1'b0;
      space_pend_q <= 1'b0;
      last_space_q <= 1'b0;
    end else begin
      space_pend_q <= word_end_c && (len_q != '0);
      if (mode_chg || ((char_end_c || word_end_c) && (len_q != '0))) begin
        sym_q <= '0;
        len_q <= '0;
        bad_q <= 1'b0;
      end else if (elem_v_c) begin
        if (len_q == LW'(MAX_SYMS)) begin
          bad_q <= 1'b1;
        end else begin
          sym_q <= {sym_q[MAX_SYMS-2:0], elem_dash_c};
          len_q <= len_q + LW'(1);
        end
      end
      if (push_c && (push_data_c == 8'h20)) last_space_q <= 1'b1;
      if (elem_v_c)                         last_space_q <= 1'b0;
    end
  end

  // FIFO
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q, count_d;
  logic            pop_c, accept_c, fifo_empty_c;

  assign fifo_empty_c = (count_q == '0);

  always_comb begin
    accept_c = push_c && (!fifo_full || pop_c);
    count_d  = count_q + CNTW'(accept_c) - CNTW'(pop_c);
  end

  always_ff @(posedge clk) begin
    if (accept_c) mem_q[wr_ptr_q] <= push_data_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fifo_full  <= 1'b0;
      overflow   <= 1'b0;
      char_out   <= 8'h00;
      char_valid <= 1'b0;
    end else begin
      char_valid <= push_c;
      if (push_c)                         char_out <= push_data_c;
      if (push_c && !accept_c)            overflow <= 1'b1;
      if (accept_c)                       wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)                          rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q   <= count_d;
      fifo_full <= (count_d == CNTW'(FIFO_DEPTH));
    end
  end

  // UART transmitter
  uart_state_e   state_q, state_d;
  logic [BW-1:0] baud_q;
  logic [3:0]    bit_q;
  logic [8:0]    shift_q;
  logic          baud_end_c;

  assign baud_end_c = (baud_q == BW'(BAUD_DIV - 1));

  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    case (state_q)
      U_IDLE: begin
        if (!fifo_empty_c) begin
          pop_c   = 1'b1;
          state_d = U_SEND;
        end
      end
      U_SEND: begin
        if (baud_end_c && (bit_q == 4'd9)) begin
          if (!fifo_empty_c) pop_c   = 1'b1;
          else               state_d = U_IDLE;
        end
      end
      default: state_d = U_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= U_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx      <= 1'b1;
      busy    <= 1'b0;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '1;
    end else if (pop_c) begin
      tx      <= 1'b0;
      busy    <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= {1'b1, mem_q[rd_ptr_q]};
    end else if (state_q == U_SEND) begin
      if (baud_end_c) begin
        baud_q <= '0;
        if (bit_q == 4'd9) begin
          tx   <= 1'b1;
          busy <= 1'b0;
        end else begin
          tx      <= shift_q[0];
          shift_q <= {1'b1, shift_q[8:1]};
          bit_q   <= bit_q + 4'd1;
        end
      end else begin
        baud_q <= baud_q + BW'(1);
      end
    end
  end

endmodule

// File: doc/morse_uart_decoder.md
# morse_uart_decoder

Parametrised Morse decoder with UART output, successor to the fixed-function Morse top. It accepts Morse elements either as discrete dot/dash/space pulses (button mode) or as a raw keyed carrier line timed against a configurable dot length (timed mode). Each decoded character is converted to ASCII, buffered in a small FIFO, and transmitted as 8N1 serial; a parallel copy is presented for local display. It sits directly under the Tiny Tapeout wrapper, fed from `ui_in` and driving `uo_out`.

## Interface
- `BAUD_DIV`, 87: clk cycles per UART bit; minimum 2.
- `MAX_SYMS`, 6: maximum elements per character; minimum 5, maximum 7.
- `FIFO_DEPTH`, 4: ASCII FIFO entries; must be a power of two, at least 2.
- `DOT_TICKS`, 1000: timed mode only; clk cycles per nominal dot.

- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `mode` in 1: 0 = button mode, 1 = timed mode.
- `dot_inp`, `dash_inp`, `char_space_inp`, `word_space_inp` in 1 each: button-mode inputs; asynchronous, rising-edge significant.
- `rx_cw` in 1: timed-mode key line; asynchronous, high = key down.
- `tx` out 1: UART 8N1, LSB first, idle high.
- `char_out` out 8: last ASCII value pushed to the FIFO.
- `char_valid` out 1: one-cycle pulse on each FIFO push.
- `fifo_full` out 1: FIFO holds `FIFO_DEPTH` entries.
- `overflow` out 1: sticky; set when a push is dropped. Cleared only by reset.
- `busy` out 1: high from start bit through stop bit.

## Operation
- **Synchronisers.** All five async inputs and `mode` pass through 2-flop synchronisers. Button inputs then go through rising-edge detectors.
- **Symbol register.**
  - Holds pattern `sym[MAX_SYMS-1:0]` and length `len`.
  - Each element shifts in at the LSB: 0 = dot, 1 = dash. The first element ends up at bit `len-1`.
- **Button-mode priority.** If several edges occur in one cycle, only one is taken: word_space > char_space > dash > dot. The others are discarded.
- **Too many elements.** An element arriving when `len==MAX_SYMS` sets an internal `bad` flag. The pattern is frozen.
- **Char end.**
  - If `len==0`: no action.
  - Otherwise: look up (`len`, `sym`) and push the ASCII result. Then clear `sym`, `len` and `bad`.
- **Lookup coverage.**
  - A–Z map to 0x41–0x5A.
  - 0–9 map to 0x30–0x39.
  - Any unmapped pattern, or `bad` set, pushes 0x3F ('?').
- **Word end.**
  - If `len>0`: perform char end this cycle and push 0x20 the next cycle (2 consecutive pushes).
  - If `len==0`: push 0x20 immediately.
  - Consecutive word ends with no elements in between push only one 0x20.
- **Timed mode.** The synchronised `rx_cw` drives a single saturating counter that restarts on every `rx_cw` transition.
  - On a falling edge, the high duration D is classified: `D < 2*DOT_TICKS` = dot, otherwise dash.
  - While low, the char end fires once when the counter reaches `3*DOT_TICKS`. The word end fires once at `7*DOT_TICKS`; it then pushes only 0x20, since `len` is already 0.
  - Button inputs are ignored in timed mode.
- **Mode change.** Any change of synchronised `mode` clears `sym`, `len`, `bad` and the timed counter. FIFO and UART are unaffected.
- **FIFO.** Push when not full. A push while full is dropped and sets `overflow`. `char_out` and `char_valid` still update on a dropped push.
- **UART.** When idle and the FIFO is non-empty: pop, then send start(0), d0..d7, stop(1), each bit held `BAUD_DIV` cycles.

## Timing
- **Reset values:** `tx`=1, `char_out`=0x00, `char_valid`=0, `fifo_full`=0, `overflow`=0, `busy`=0. Symbol register, counters and FIFO pointers are cleared.
- Reset mid-frame forces `tx` high asynchronously and discards the FIFO contents.
- **Button latency.** Pin rising edge sampled at clk edge N:
  - edge detected at N+2;
  - symbol register / FIFO push effective at N+3;
  - `char_valid` high during the cycle after N+3.
- **UART start.** The start bit begins the cycle after the FIFO goes non-empty, if idle. `busy` rises the same cycle.
- **UART frame.** A frame is exactly `10*BAUD_DIV` cycles; `busy` falls at its end. A back-to-back pop starts the next start bit the cycle after the stop bit ends.
- **Simultaneous push and pop.** On a full FIFO this succeeds: the pop happens first, so the push is accepted and `overflow` is not set.
- **Counter width.** The timed counter is wide enough for `7*DOT_TICKS` and saturates there, with no wrap.

## Test plan
- **Button "SOS".** Button mode, `BAUD_DIV`=4: dot×3, char_space, dash×3, char_space, dot×3, char_space. Required: `tx` carries 0x53, 0x4F, 0x53, each frame 40 cycles; `char_valid` pulses 3 times.
- **Word space and unmapped pattern.** Dash, dot, word_space, then 6 dots, char_space. Required: pushes 0x4E, 0x20, then 0x3F.
- **Too many elements.** 7 dots with `MAX_SYMS`=6, then char_space. Required: 0x3F pushed; the next "E" (dot, char_space) decodes as 0x45.
- **Timed mode.** `DOT_TICKS`=10: `rx_cw` high 10, low 10, high 30, then low 80 cycles. Required: 0x41 pushed at low count 30, then 0x20 pushed at low count 70, exactly once.
- **FIFO overflow.** `FIFO_DEPTH`=2, 4 chars entered within one UART frame. Required: `fifo_full`=1, `overflow`=1 sticky, 3 chars transmitted (1 in flight + 2 buffered).
- **Reset and mode change mid-operation.** `rst_n` low mid-frame: `tx`=1 the same cycle, all outputs return to reset values. Toggling `mode` with `len`=2 pending: next char_space pushes nothing.
